uart_hex_tx_sender: RTL
=======================

Name: uart_hex_tx_sender

Overview:
Opposite direction of the UART-to-SSD display path. On a debounced button press or a one-cycle request, it latches an 8-bit value from the board switches. It transmits that value as four ASCII characters over UART 8N1: high hex nibble, low hex nibble, CR, LF. It contains its own debouncer, formatter FSM and bit serializer, and sits alongside the receive/display logic on the same 50 MHz board.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button level change is accepted (20 ms)

Ports:
clk  input  1  50 MHz system clock
rst  input  1  asynchronous active-low reset (board reset button)
send_btn  input  1  raw active-low push button, asynchronous to clk
send_req  input  1  synchronous one-cycle send request from other logic
switch_data  input  8  value to transmit, sampled at trigger
uart_txd  output  1  UART serial output, idle high
busy  output  1  high from the trigger cycle until the last stop bit completes
tx_done  output  1  one-cycle pulse on the cycle after the LF stop bit ends

Behaviour:
- Reset (rst=0, asynchronous): uart_txd=1, busy=0, tx_done=0, FSM=IDLE, all counters 0, debounced button state=1 (released), synchronizer flops=1.
- Button path: send_btn passes through a 2-flop synchronizer. The debounced level changes only after the synchronized input holds the opposite level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- A press event is a debounced 1->0 transition and lasts one cycle. Release generates nothing.
- Trigger = press event OR send_req. If both occur in the same cycle, one message is sent.
- A trigger in IDLE is accepted: switch_data is latched, busy=1 on the next edge, and the FSM enters START for character 0.
- A trigger while busy=1 is ignored and not queued. The latched data is not updated.
- Changes on switch_data after acceptance do not affect the message in flight.
- Character encoding: nibble n<10 gives 0x30+n. n>=10 gives 0x37+n (uppercase A-F).
- Character order: idx0=hex(data[7:4]), idx1=hex(data[3:0]), idx2=0x0D, idx3=0x0A.
- FSM states: IDLE, START, DATA, STOP.
  - START: uart_txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit index wraps 7->0 on exit.
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles.
- After STOP: if idx<3, idx increments and the FSM goes directly to START with no idle gap. If idx=3, the FSM goes to IDLE, busy=0 and tx_done=1 for one cycle.
- Latency: uart_txd falls on the first clk edge after the trigger cycle. The total message is 40*CLKS_PER_BIT cycles of line time.
- A new trigger is accepted in the same cycle tx_done pulses (busy is already 0 that cycle).
- uart_txd is driven from a register, so it has no glitches.
- Baud counter width: clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps.
- Debounce counter width: clog2(DEBOUNCE_CYCLES+1).
- Reset mid-frame aborts immediately: uart_txd returns high asynchronously and no tx_done pulse is produced.

Test Plan:
(Bench uses CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8.)
- switch_data=0x3A, send_req pulse -> uart_txd carries 0x33,0x41,0x0D,0x0A, each framed start/LSB-first/stop, 160 cycles total. busy high for 160 cycles, then one tx_done pulse.
- send_btn bounces 0/1 every 3 cycles for 30 cycles, then holds 0 -> exactly one message, beginning 8+2 cycles after the last bounce (2-flop synchronizer plus debounce count). Release with bounce -> no message.
- switch_data=0xF0 sent; send_req pulsed again at cycle 50 and switch_data changed to 0x11 -> only "F0\r\n" is sent, and the second request is dropped.
- send_req asserted on the tx_done cycle with switch_data=0x09 -> second message "09\r\n" starts on the next edge, and busy stays high after only a single low cycle.
- send_req and a debounced press in the same cycle -> one message only.
- rst driven low during the DATA bits of char 1 -> uart_txd=1 and busy=0 without waiting for a clk edge, with no tx_done. After release, send_req sends a complete message.

Source files
------------

// File: rtl/uart_hex_tx_sender_if.sv
// Handshake/data bundle for the hex-over-UART sender: trigger inputs,
// the switch value and the serial line plus status outputs.
interface uart_hex_tx_sender_if;
    logic       send_btn;
    logic       send_req;
    logic [7:0] switch_data;
    logic       uart_txd;
    logic       busy;
    logic       tx_done;

    modport master (
        output send_btn,
        output send_req,
        output switch_data,
        input  uart_txd,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  send_btn,
        input  send_req,
        input  switch_data,
        output uart_txd,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_hex_tx_sender.sv
// Latches an 8-bit switch value on a debounced button press or a request
// pulse and sends it over UART 8N1 as two uppercase hex digits, CR, LF.
module uart_hex_tx_sender #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_hex_tx_sender_if.slave  bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ASCII for one hex nibble, uppercase letters.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    // Character at position idx of the message "HL\r\n".
    function automatic logic [7:0] msg_char(input logic [7:0] data, input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = hex_char(data[7:4]);
            2'd1:    c = hex_char(data[3:0]);
            2'd2:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    logic              r_btn_meta;
    logic              r_btn_sync;
    logic              r_btn_db;
    logic [DB_W-1:0]   r_db_cnt;
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [1:0]        r_idx;
    logic [7:0]        r_data;
    logic              r_txd;
    logic              r_busy;
    logic              r_done;

    logic              w_press;
    logic              w_trigger;
    logic              w_baud_last;
    state_t            w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_nxt;
    logic [1:0]        w_idx_nxt;
    logic [7:0]        w_data_nxt;
    logic [7:0]        w_char_nxt;
    logic              w_txd_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    // Two-flop synchronizer for the asynchronous button (idles released = 1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
        end else begin
            r_btn_meta <= bus.send_btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debouncer: accept a level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_btn_sync == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_btn_sync;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    // The press event is the cycle in which a debounced 1->0 change is accepted.
    assign w_press     = r_btn_db & ~r_btn_sync & (r_db_cnt == DB_LAST);
    assign w_trigger   = w_press | bus.send_req;
    assign w_baud_last = (r_baud == BAUD_LAST);

    // State and counter registers, plus registered line/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_idx   <= 2'd0;
            r_data  <= 8'h00;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: frame sequencing and character stepping; triggers only land in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_idx_nxt   = 2'd0;
                    w_data_nxt  = bus.switch_data;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt  = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_char_nxt = msg_char(w_data_nxt, w_idx_nxt);

    // Output logic: values the line and status flags take after the coming edge.
    always_comb begin
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                w_done_nxt = (r_state == S_STOP);
            end
            S_START: begin
                w_txd_nxt  = 1'b0;
                w_busy_nxt = 1'b1;
            end
            S_DATA: begin
                w_txd_nxt  = w_char_nxt[w_bit_nxt];
                w_busy_nxt = 1'b1;
            end
            S_STOP: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign bus.uart_txd = r_txd;
    assign bus.busy     = r_busy;
    assign bus.tx_done  = r_done;
endmodule
